// File: rtl/intra_pkg.sv
// Shared intra-prediction constants: cost width, mode encodings, bit estimates, FSM states.
package intra_pkg;

   localparam int LAMBDA_W = 7;
   // SAD (16b) plus lambda*bits (max 91*15) never exceeds 17 bits.
   localparam int COST_W   = 17;

   typedef enum logic [3:0] {
      I4_V = 4'd0, I4_H, I4_DC, I4_DDL, I4_DDR, I4_VR, I4_HD, I4_VL, I4_HU
   } i4_mode_e;

   typedef enum logic [3:0] {
      I16_V = 4'd0, I16_H, I16_DC, I16_PLANE
   } i16_mode_e;

   localparam int I4_NUM_MODES  = 9;
   localparam int I16_NUM_MODES = 4;

   localparam logic [3:0] BITS_PRED  = 4'd1;
   localparam logic [3:0] BITS_OTHER = 4'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/intra_cost_calc.sv
// Two-stage cost pipe: stage 1 registers lambda*bits, stage 2 registers SAD+product.
// Two cycles of latency, no stall; flush_i clears both valid bits.
module intra_cost_calc
   import intra_pkg::*;
#(
   parameter int SAD_W  = 16,
   parameter int BITS_W = 4,
   parameter int MODE_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   input  logic                in_vld_i,
   input  logic [LAMBDA_W-1:0] lambda_i,
   input  logic [SAD_W-1:0]    sad_i,
   input  logic [BITS_W-1:0]   bits_i,
   input  logic [MODE_W-1:0]   mode_i,
   input  logic                last_i,
   output logic                cost_vld_o,
   output logic [SAD_W:0]      cost_o,
   output logic [MODE_W-1:0]   mode_o,
   output logic                last_o
);

   localparam int PROD_W = LAMBDA_W + BITS_W;
   localparam int CW     = SAD_W + 1;

   logic              v1_q, v2_q;
   logic [SAD_W-1:0]  sad_q;
   logic [PROD_W-1:0] prod_q;
   logic [MODE_W-1:0] mode1_q, mode2_q;
   logic              last1_q, last2_q;
   logic [CW-1:0]     cost_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         sad_q   <= '0;
         prod_q  <= '0;
         mode1_q <= '0;
         mode2_q <= '0;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
         cost_q  <= '0;
      end else begin
         v1_q    <= in_vld_i & ~flush_i;
         v2_q    <= v1_q & ~flush_i;
         sad_q   <= sad_i;
         prod_q  <= PROD_W'(lambda_i) * PROD_W'(bits_i);
         mode1_q <= mode_i;
         last1_q <= last_i;
         cost_q  <= CW'(sad_q) + CW'(prod_q);
         mode2_q <= mode1_q;
         last2_q <= last1_q;
      end
   end

   assign cost_vld_o = v2_q;
   assign cost_o     = cost_q;
   assign mode_o     = mode2_q;
   assign last_o     = last2_q;

endmodule

// File: rtl/intra_mode_decision.sv
// RD intra mode selector: picks min(SAD + lambda*bits) per block; done_o two edges after last candidate.
// Candidates accepted every cycle with no backpressure; start_i aborts and restarts any block.
module intra_mode_decision
   import intra_pkg::*;
#(
   parameter int SAD_W  = 16,
   parameter int BITS_W = 4,
   parameter int MODE_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [6:0]          lambda_i,
   input  logic                mode_valid_i,
   input  logic [MODE_W-1:0]   mode_i,
   input  logic [SAD_W-1:0]    sad_i,
   input  logic [BITS_W-1:0]   bits_i,
   input  logic                last_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [MODE_W-1:0]   best_mode_o,
   output logic [SAD_W:0]      best_cost_o
);

   state_e              state_q;
   logic                busy_q, done_q;
   logic [LAMBDA_W-1:0] lambda_q;
   logic [MODE_W-1:0]   best_mode_q;
   logic [SAD_W:0]      best_cost_q;

   logic                accept;
   logic                cost_vld;
   logic [SAD_W:0]      cost;
   logic [MODE_W-1:0]   cost_mode;
   logic                cost_last;

   // A candidate coinciding with start_i belongs to the aborted block.
   assign accept = (state_q == S_ACC) && mode_valid_i && !start_i;

   intra_cost_calc #(
      .SAD_W  (SAD_W),
      .BITS_W (BITS_W),
      .MODE_W (MODE_W)
   ) u_cost (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (start_i),
      .in_vld_i   (accept),
      .lambda_i   (lambda_q),
      .sad_i      (sad_i),
      .bits_i     (bits_i),
      .mode_i     (mode_i),
      .last_i     (last_i),
      .cost_vld_o (cost_vld),
      .cost_o     (cost),
      .mode_o     (cost_mode),
      .last_o     (cost_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         lambda_q    <= '0;
         best_mode_q <= '0;
         best_cost_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            state_q     <= S_ACC;
            busy_q      <= 1'b1;
            lambda_q    <= lambda_i;
            best_cost_q <= '1;
            best_mode_q <= '0;
         end else begin
            // Strict compare keeps the earlier candidate on a tie.
            if (cost_vld && (cost < best_cost_q)) begin
               best_cost_q <= cost;
               best_mode_q <= cost_mode;
            end
            case (state_q)
               S_ACC: begin
                  if (accept && last_i) state_q <= S_DRAIN;
               end
               S_DRAIN: begin
                  if (cost_vld && cost_last) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign best_mode_o = best_mode_q;
   assign best_cost_o = best_cost_q;

endmodule

// File: tb/tb_intra_mode_decision.sv
// Directed bench with a scoreboard of per-block winners checked on every done_o pulse.
module tb_intra_mode_decision;
   import intra_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_i;
   logic [6:0]        lambda_i;
   logic              mode_valid_i;
   logic [3:0]        mode_i;
   logic [15:0]       sad_i;
   logic [3:0]        bits_i;
   logic              last_i;
   logic              busy_o;
   logic              done_o;
   logic [3:0]        best_mode_o;
   logic [COST_W-1:0] best_cost_o;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [COST_W+3:0] exp_q[$];
   logic [6:0]        cur_lam;
   logic [COST_W-1:0] cur_cost;
   logic [3:0]        cur_mode;

   always #5 clk = ~clk;

   intra_mode_decision dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .lambda_i     (lambda_i),
      .mode_valid_i (mode_valid_i),
      .mode_i       (mode_i),
      .sad_i        (sad_i),
      .bits_i       (bits_i),
      .last_i       (last_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .best_mode_o  (best_mode_o),
      .best_cost_o  (best_cost_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done_o pulse must match the oldest pending block result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done_o === 1'b1) begin
         logic [COST_W+3:0] e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_mode", 32'(best_mode_o), 32'(e[COST_W+3:COST_W]));
            chk("sb_cost", 32'(best_cost_o), 32'(e[COST_W-1:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [6:0] lam);
      start_i = 1'b1;
      lambda_i = lam;
      step();
      start_i = 1'b0;
      lambda_i = 7'h55;
      cur_lam = lam;
      cur_cost = '1;
      cur_mode = '0;
   endtask

   task automatic send(input logic [3:0] m, input logic [15:0] s, input logic [3:0] b, input bit last);
      logic [COST_W-1:0] c;
      mode_valid_i = 1'b1;
      mode_i = m;
      sad_i = s;
      bits_i = b;
      last_i = last;
      c = COST_W'(s) + COST_W'(cur_lam) * COST_W'(b);
      if (c < cur_cost) begin
         cur_cost = c;
         cur_mode = m;
      end
      step();
      mode_valid_i = 1'b0;
      last_i = 1'b0;
      if (last) exp_q.push_back({cur_mode, cur_cost});
   endtask

   task automatic wait_done(input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done_o === 1'b1) begin
            got = 1'b1;
            break;
         end
         step();
      end
      chk(tag, 32'(got), 32'd1);
   endtask

   initial begin
      int d0;
      rst_n = 1'b0;
      start_i = 1'b0;
      lambda_i = '0;
      mode_valid_i = 1'b0;
      mode_i = '0;
      sad_i = '0;
      bits_i = '0;
      last_i = 1'b0;
      #12;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_mode", 32'(best_mode_o), 32'd0);
      chk("rst_cost", 32'(best_cost_o), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic block with exact latency check.
      do_start(7'd4);
      chk("busy_rise", 32'(busy_o), 32'd1);
      send(4'd0, 16'd100, BITS_PRED, 1'b0);
      send(4'd1, 16'd95, BITS_OTHER, 1'b0);
      send(4'd2, 16'd90, BITS_OTHER, 1'b1);
      chk("lat_t1_done", 32'(done_o), 32'd0);
      step();
      chk("lat_t2_done", 32'(done_o), 32'd0);
      chk("lat_t2_busy", 32'(busy_o), 32'd1);
      step();
      chk("lat_done", 32'(done_o), 32'd1);
      chk("lat_busy_fall", 32'(busy_o), 32'd0);
      chk("basic_mode", 32'(best_mode_o), 32'd0);
      chk("basic_cost", 32'(best_cost_o), 32'd104);
      step();
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("hold_cost", 32'(best_cost_o), 32'd104);

      // Tie: earlier candidate wins.
      do_start(7'd1);
      send(4'd3, 16'd50, BITS_PRED, 1'b0);
      send(4'd5, 16'd47, BITS_OTHER, 1'b1);
      wait_done("tie_done");
      chk("tie_mode", 32'(best_mode_o), 32'd3);
      chk("tie_cost", 32'(best_cost_o), 32'd51);
      step();

      // Maximum operands, single candidate with last.
      do_start(7'd91);
      send(4'd8, 16'hFFFF, 4'd15, 1'b1);
      wait_done("max_done");
      chk("max_cost", 32'(best_cost_o), 32'd66900);
      chk("max_mode", 32'(best_mode_o), 32'd8);
      step();

      // Abort: cheap candidates before the restart must not survive.
      d0 = done_cnt;
      do_start(7'd4);
      send(4'd1, 16'd1, 4'd0, 1'b0);
      send(4'd2, 16'd1, 4'd0, 1'b0);
      start_i = 1'b1;
      lambda_i = 7'd2;
      mode_valid_i = 1'b1;
      mode_i = 4'd4;
      sad_i = 16'd0;
      bits_i = 4'd0;
      last_i = 1'b1;
      step();
      start_i = 1'b0;
      lambda_i = 7'd90;
      mode_valid_i = 1'b0;
      last_i = 1'b0;
      cur_lam = 7'd2;
      cur_cost = '1;
      cur_mode = '0;
      send(4'd7, 16'd10, BITS_PRED, 1'b1);
      wait_done("abort_done");
      chk("abort_mode", 32'(best_mode_o), 32'd7);
      chk("abort_cost", 32'(best_cost_o), 32'd12);
      step();
      step();
      chk("abort_one_done", 32'(done_cnt - d0), 32'd1);

      // Back-to-back blocks, next start in the done_o cycle.
      d0 = done_cnt;
      do_start(7'd10);
      for (int i = 0; i < I4_NUM_MODES; i++)
         send(4'(i), 16'($urandom_range(200, 400)), (i == 2) ? BITS_PRED : BITS_OTHER, i == I4_NUM_MODES - 1);
      wait_done("b2b_done1");
      do_start(7'd3);
      for (int i = 0; i < I4_NUM_MODES; i++)
         send(4'(i), 16'($urandom_range(200, 400)), (i == 5) ? BITS_PRED : BITS_OTHER, i == I4_NUM_MODES - 1);
      wait_done("b2b_done2");
      step();
      chk("b2b_two_done", 32'(done_cnt - d0), 32'd2);

      // Asynchronous reset mid-block.
      do_start(7'd5);
      send(4'd1, 16'd20, BITS_PRED, 1'b0);
      send(4'd2, 16'd30, BITS_PRED, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_cost", 32'(best_cost_o), 32'd0);
      chk("arst_mode", 32'(best_mode_o), 32'd0);
      step();
      rst_n = 1'b1;
      d0 = done_cnt;
      mode_valid_i = 1'b1;
      last_i = 1'b1;
      for (int i = 0; i < 6; i++) step();
      mode_valid_i = 1'b0;
      last_i = 1'b0;
      chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("arst_idle_busy", 32'(busy_o), 32'd0);

      // Recovery block after reset, lambda zero.
      do_start(7'd0);
      send(4'd2, 16'd9, BITS_OTHER, 1'b0);
      send(4'd0, 16'd7, BITS_OTHER, 1'b1);
      wait_done("post_rst_done");
      chk("post_rst_cost", 32'(best_cost_o), 32'd7);
      step();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
